// File: rtl/result_pipe_pkg.sv
// Shared types for the result/tag pipe: per-stage entry layout and stage-index sizing.
package result_pipe_pkg;

    localparam int PIPE_DATA_W  = 128;
    localparam int PIPE_ADDR_W  = 7;
    localparam int PIPE_DEPTH   = 7;
    localparam int PIPE_NUM_SRC = 3;

    typedef struct packed {
        logic                   v;
        logic                   we;
        logic                   dv;
        logic [PIPE_ADDR_W-1:0] addr;
        logic [PIPE_DATA_W-1:0] data;
    } entry_t;

    // Bits needed to hold 0..depth, covering both stage numbers and a full occupancy count.
    function automatic int stage_idx_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/result_tag_pipe_fwd_select.sv
// Single-source forwarding matcher: selects the youngest (lowest-numbered) stage
// that writes the queried register and reports whether its data is ready yet.
module fwd_select
    import result_pipe_pkg::*;
#(
    parameter int DEPTH = PIPE_DEPTH
) (
    input  entry_t [DEPTH-1:0]     stages,
    input  logic [PIPE_ADDR_W-1:0] q_addr,
    output logic                   hit,
    output logic                   pending,
    output logic [PIPE_DATA_W-1:0] data
);

    // Only the first match counts, so an older completed entry can never
    // hide a younger one that is still waiting for its result.
    always_comb begin
        logic found;
        found   = 1'b0;
        hit     = 1'b0;
        pending = 1'b0;
        data    = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if (!found && stages[s].v && stages[s].we && (stages[s].addr == q_addr)) begin
                found   = 1'b1;
                hit     = stages[s].dv;
                pending = !stages[s].dv;
                data    = stages[s].dv ? stages[s].data : '0;
            end
        end
    end

endmodule

// File: rtl/result_tag_pipe.sv
// Result/tag shift pipe between issue and register-file writeback, with result
// injection at any stage, youngest-match forwarding, hold, flush and error tracking.
module result_tag_pipe
    import result_pipe_pkg::*;
#(
    parameter int DATA_W  = PIPE_DATA_W,
    parameter int ADDR_W  = PIPE_ADDR_W,
    parameter int DEPTH   = PIPE_DEPTH,
    parameter int NUM_SRC = PIPE_NUM_SRC,
    parameter int STG_W   = stage_idx_w(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      iss_valid,
    input  logic                      iss_we,
    input  logic [ADDR_W-1:0]         iss_addr,
    output logic                      iss_ready,
    input  logic                      res_valid,
    input  logic [STG_W-1:0]          res_stage,
    input  logic [DATA_W-1:0]         res_data,
    input  logic                      hold,
    input  logic                      flush,
    input  logic [NUM_SRC*ADDR_W-1:0] q_addr,
    output logic [NUM_SRC-1:0]        fwd_hit,
    output logic [NUM_SRC-1:0]        fwd_pending,
    output logic [NUM_SRC*DATA_W-1:0] fwd_data,
    output logic                      wb_valid,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic [DATA_W-1:0]         wb_data,
    output logic [STG_W-1:0]          occupancy,
    output logic                      err
);

    entry_t [DEPTH:1] stg;
    entry_t [DEPTH:1] nxt;
    entry_t           last;
    logic             err_set;
    logic             stage_ok;
    logic [STG_W-1:0] nxt_count;

    assign last      = stg[DEPTH];
    assign iss_ready = !hold;

    // Flush kills everything currently in stages 1..DEPTH-1 plus the new issue.
    // When shifting, those entries land in stages 2..DEPTH, so every stage ends
    // up empty; the entry now in stage DEPTH still writes back this cycle.
    always_comb begin
        nxt       = stg;
        err_set   = 1'b0;
        stage_ok  = 1'b0;
        nxt_count = '0;
        if (!hold) begin
            nxt[1]      = '0;
            nxt[1].v    = iss_valid;
            nxt[1].we   = iss_we;
            nxt[1].addr = iss_addr;
            for (int s = 2; s <= DEPTH; s++) begin
                nxt[s] = stg[s-1];
                if (res_stage == STG_W'(s)) begin
                    stage_ok = 1'b1;
                    if (res_valid) begin
                        if (stg[s-1].v && stg[s-1].we) begin
                            nxt[s].dv   = 1'b1;
                            nxt[s].data = res_data;
                        end else if (!flush) begin
                            err_set = 1'b1;
                        end
                    end
                end
            end
            if (res_valid && !stage_ok) begin
                err_set = 1'b1;
            end
            if (flush) begin
                for (int s = 1; s <= DEPTH; s++) begin
                    nxt[s].v = 1'b0;
                end
            end
        end else begin
            if (res_valid) begin
                err_set = 1'b1;
            end
            if (flush) begin
                for (int s = 1; s < DEPTH; s++) begin
                    nxt[s].v = 1'b0;
                end
            end
        end
        if (last.v && last.we && !last.dv) begin
            err_set = 1'b1;
        end
        for (int s = 1; s <= DEPTH; s++) begin
            nxt_count = nxt_count + STG_W'(nxt[s].v);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg       <= '0;
            occupancy <= '0;
            err       <= 1'b0;
        end else begin
            stg       <= nxt;
            occupancy <= nxt_count;
            err       <= err | err_set;
        end
    end

    assign wb_valid = last.v && last.we && last.dv;
    assign wb_addr  = wb_valid ? last.addr : '0;
    assign wb_data  = wb_valid ? last.data : '0;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        fwd_select #(.DEPTH(DEPTH)) u_sel (
            .stages  (stg),
            .q_addr  (q_addr[i*ADDR_W +: ADDR_W]),
            .hit     (fwd_hit[i]),
            .pending (fwd_pending[i]),
            .data    (fwd_data[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: doc/result_tag_pipe.md
Name: result_tag_pipe

Overview:
- Parametrised successor to the fixed 7-stage even-pipe result/tag shifter.
- Carries one {write-enable, destination address, data} entry per stage through DEPTH stages.
- Accepts a completing unit's result at any programmable stage and performs youngest-match operand forwarding for NUM_SRC source operands, with pending-hazard indication.
- Adds hold (stall), flush, occupancy count and sticky protocol-error flag; sits between issue logic and register-file writeback.

Parameters:
DATA_W, 128, result width in bits
ADDR_W, 7, register address width
DEPTH, 7, number of pipe stages (2..16)
NUM_SRC, 3, forwarding lookup ports
STG_W, $clog2(DEPTH+1), stage-index width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
iss_valid  input  1  new instruction enters stage 1
iss_we  input  1  instruction writes a register
iss_addr  input  ADDR_W  destination register
iss_ready  output  1  issue accepted this cycle (= !hold)
res_valid  input  1  unit result available
res_stage  input  STG_W  stage index (2..DEPTH) the result lands in
res_data  input  DATA_W  result value
hold  input  1  freeze all stages
flush  input  1  kill stages 1..DEPTH-1
q_addr  input  NUM_SRC*ADDR_W  source addresses to look up, src i at bits [i*ADDR_W +: ADDR_W]
fwd_hit  output  NUM_SRC  youngest match has data
fwd_pending  output  NUM_SRC  youngest match has no data yet
fwd_data  output  NUM_SRC*DATA_W  forwarded values, same packing as q_addr
wb_valid  output  1  writeback strobe
wb_addr  output  ADDR_W  writeback address
wb_data  output  DATA_W  writeback value
occupancy  output  STG_W  count of valid entries
err  output  1  sticky protocol error

Behaviour:
- Entry per stage s=1..DEPTH: v, we, dv (data valid), addr, data.
- Reset (reset=0, async): all fields 0; err=0; occupancy=0; every output 0 except iss_ready=1.
- Advance (hold=0): stage[s] <= stage[s-1]; stage[1] <= {iss_valid, iss_we, dv=0, iss_addr, 0}. Stage DEPTH entry retires.
- Result injection (hold=0, res_valid=1, res_stage=k):
  - stage[k] takes stage[k-1] with dv=1 and data=res_data.
  - If stage[k-1].v=0 or stage[k-1].we=0: data dropped, err<=1.
  - res_stage<2 or >DEPTH: dropped, err<=1.
- Hold=1:
  - No shift, issue ignored, iss_ready=0.
  - res_valid=1 is dropped and sets err.
  - flush still applies.
- Flush=1: v of stages 1..DEPTH-1 cleared at the edge after the shift.
  - Stage DEPTH (retiring/writeback) is unaffected.
  - Same-cycle issue is also killed.
  - Flush has priority over injection into killed stages; no err in that case.
- Writeback, combinational from stage DEPTH:
  - wb_valid = v & we & dv; wb_addr/wb_data from that stage, 0 when wb_valid=0.
  - v & we & !dv at stage DEPTH: err<=1 at the next edge, wb_valid=0.
- Latency: issue in cycle t appears at stage DEPTH, wb visible in cycle t+DEPTH, plus held cycles.
- Forwarding, combinational from registers:
  - For each src i, scan s=1..DEPTH and select the lowest s with v & we & addr==q_addr[i].
  - Selected entry dv=1: fwd_hit[i]=1, fwd_data[i]=data.
  - Selected entry dv=0: fwd_pending[i]=1, fwd_data[i]=0.
  - No match: both flags 0, fwd_data[i]=0.
  - An older completed match never overrides a younger pending one.
- occupancy: registered popcount of v after each edge; reaches DEPTH when full. A full pipe still shifts, since retirement frees stage DEPTH.
- err: cleared only by reset.

Decomposition:
- Package result_pipe_pkg: entry struct typedef {v, we, dv, addr, data} parametrised via package constants, and the stage-index helper function.
- One sub-module, fwd_select: single-source priority matcher, instantiated NUM_SRC times.

Test Plan:
- Straight flow (DEPTH=7):
  - Issue we=1 addr=5 in cycle 0; res_stage=3 data=0xAA..AA in cycle 2.
  - Expect wb_valid=1, wb_addr=5, wb_data=0xAA..AA in cycle 7 only; occupancy 1 during cycles 1-7.
- Youngest-match forwarding:
  - Issue addr=9 twice, cycles 0 and 1; complete the older one only (res_stage=2, cycle 1, data=0x11).
  - In cycle 2, q_addr=9 gives fwd_pending=1, fwd_hit=0.
  - Complete the younger one (res_stage=3, cycle 3, data=0x22); in cycle 4, fwd_hit=1, fwd_data=0x22.
- Hold:
  - Issue at cycle 0; hold=1 cycles 2-4 with iss_valid=1 each cycle.
  - wb shifts to cycle 10; held issues are dropped; iss_ready=0 during hold.
- Flush: 6 entries in flight plus 1 at stage 7; flush=1 leaves only the stage-7 writeback; occupancy=0 next cycle.
- Errors, each in isolation:
  - res_stage=4 while stage 3 is empty sets err=1.
  - A we entry reaching stage 7 with dv=0 sets err=1.
  - err stays 1 until reset.
- Async reset mid-flight: drop reset between edges; outputs zero immediately, nothing written back after reset releases.
